// File: rtl/vx_clone_sequencer_pkg.sv
// Shared parameters and types for the warp-context clone sequencer.
//   NT        threads per warp (lane 0 = master, lanes 1..NT-1 = slaves)
//   NUM_REGS  architectural registers per thread (x0 is never copied)
//   RW        register index width
//   clone_state_e  sequencer FSM states
package vx_clone_sequencer_pkg;

  localparam int unsigned NT       = 4;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned RW       = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StFixup,
    StDone
  } clone_state_e;

endpackage

// File: rtl/vx_clone_sequencer_if.sv
// Bundle of the clone request handshake, master read port, master writeback snoop and
// slave copy-write port.
//   master modport: context/issue side (drives in_*, observes out_*)
//   slave  modport: the clone sequencer (observes in_*, drives out_*)
interface vx_clone_sequencer_if;
  import vx_clone_sequencer_pkg::*;

  logic          in_clone_valid;
  logic [NT-1:0] in_clone_mask;
  logic          out_clone_ready;
  logic          out_stall;
  logic [RW-1:0] out_rd_addr;
  logic [31:0]   in_rd_data;
  logic          in_wb_valid;
  logic [RW-1:0] in_wb_rd;
  logic [31:0]   in_wb_data;
  logic [NT-1:0] out_copy_en;
  logic [RW-1:0] out_copy_rd;
  logic [31:0]   out_copy_data;
  logic          out_done;

  modport master (
    output in_clone_valid, in_clone_mask, in_rd_data, in_wb_valid, in_wb_rd, in_wb_data,
    input  out_clone_ready, out_stall, out_rd_addr, out_copy_en, out_copy_rd, out_copy_data,
           out_done
  );

  modport slave (
    input  in_clone_valid, in_clone_mask, in_rd_data, in_wb_valid, in_wb_rd, in_wb_data,
    output out_clone_ready, out_stall, out_rd_addr, out_copy_en, out_copy_rd, out_copy_data,
           out_done
  );

endinterface

// File: rtl/vx_clone_sequencer_find_first.sv
// Lowest-set-bit encoder.
//   vec_i    input vector
//   valid_o  any bit set
//   idx_o    index of the lowest set bit (0 when none set)
module vx_clone_sequencer_find_first #(
  parameter int unsigned Width = 32,
  parameter int unsigned IdxW  = $clog2(Width)
) (
  input  logic [Width-1:0] vec_i,
  output logic             valid_o,
  output logic [IdxW-1:0]  idx_o
);

  always_comb begin
    valid_o = |vec_i;
    idx_o   = '0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = Width - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IdxW'(i);
    end
  end

endmodule

// File: rtl/vx_clone_sequencer.sv
// Warp-context clone sequencer. Copies the master register file (thread 0) into the selected
// slave thread register files, one register per cycle, while holding decode/issue. Writebacks
// that land on already-copied registers are remembered in a dirty vector and re-copied in a
// fixup pass so the slaves end coherent with the master.
//   clk    clock, all state on the rising edge
//   reset  synchronous, active-high; abandons any clone in flight
//   bus    slave view of vx_clone_sequencer_if:
//            clone request/ready, stall, master read port, writeback snoop,
//            registered slave copy-write port, one-cycle done pulse
module vx_clone_sequencer
  import vx_clone_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  vx_clone_sequencer_if.slave   bus
);

  clone_state_e        state_q, state_d;
  logic [RW-1:0]       idx_q, idx_d;
  logic [NT-1:0]       mask_q, mask_d;
  logic [NUM_REGS-1:0] dirty_q, dirty_d;

  // Copy stage: the register read in cycle N is written to the slaves in cycle N+1.
  logic                copy_vld_q, copy_vld_d;
  logic [RW-1:0]       copy_rd_q, copy_rd_d;
  logic [31:0]         copy_data_q, copy_data_d;

  logic                ff_valid;
  logic [RW-1:0]       ff_idx;

  logic                rd_active;
  logic [RW-1:0]       rd_addr;
  logic [31:0]         rd_captured;
  logic [NUM_REGS-1:0] dirty_set, dirty_clr;
  logic [NT-1:0]       req_mask;
  logic                ready, stall, done;

  // Lane 0 is the master and is never a copy target.
  assign req_mask = {bus.in_clone_mask[NT-1:1], 1'b0};

  vx_clone_sequencer_find_first #(
    .Width (NUM_REGS),
    .IdxW  (RW)
  ) u_find_first (
    .vec_i   (dirty_q),
    .valid_o (ff_valid),
    .idx_o   (ff_idx)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    copy_vld_d  = 1'b0;
    copy_rd_d   = '0;
    copy_data_d = '0;
    rd_active   = 1'b0;
    rd_addr     = '0;
    rd_captured = '0;
    dirty_set   = '0;
    dirty_clr   = '0;
    ready       = 1'b0;
    stall       = 1'b1;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        stall = bus.in_clone_valid;
        if (bus.in_clone_valid) begin
          mask_d  = req_mask;
          idx_d   = RW'(1);
          state_d = (req_mask == '0) ? StDone : StSweep;
        end
      end

      StSweep: begin
        rd_active = 1'b1;
        rd_addr   = idx_q;
        // Only registers already read can go stale; a hit on idx_q is bypassed below.
        if (bus.in_wb_valid && (bus.in_wb_rd != '0) && (bus.in_wb_rd < idx_q)) begin
          dirty_set[bus.in_wb_rd] = 1'b1;
        end
        if (idx_q == RW'(NUM_REGS - 1)) begin
          state_d = StFixup;
        end else begin
          idx_d = idx_q + RW'(1);
        end
      end

      StFixup: begin
        if (ff_valid) begin
          rd_active          = 1'b1;
          rd_addr            = ff_idx;
          dirty_clr[ff_idx]  = 1'b1;
        end
        if (bus.in_wb_valid && (bus.in_wb_rd != '0) &&
            !(rd_active && (bus.in_wb_rd == rd_addr))) begin
          dirty_set[bus.in_wb_rd] = 1'b1;
        end
        // Finish only once nothing is pending, nothing newly stale, and no copy issued now.
        if (!ff_valid && (dirty_set == '0)) begin
          state_d = StDone;
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (rd_active) begin
      rd_captured = (bus.in_wb_valid && (bus.in_wb_rd == rd_addr)) ? bus.in_wb_data
                                                                   : bus.in_rd_data;
      copy_vld_d  = 1'b1;
      copy_rd_d   = rd_addr;
      copy_data_d = rd_captured;
    end

    // Set wins over clear so a register rewritten while being cleared is copied again.
    dirty_d    = (dirty_q & ~dirty_clr) | dirty_set;
    dirty_d[0] = 1'b0;
    if (state_q == StIdle) begin
      dirty_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= RW'(1);
      mask_q      <= '0;
      dirty_q     <= '0;
      copy_vld_q  <= 1'b0;
      copy_rd_q   <= '0;
      copy_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      dirty_q     <= dirty_d;
      copy_vld_q  <= copy_vld_d;
      copy_rd_q   <= copy_rd_d;
      copy_data_q <= copy_data_d;
    end
  end

  assign bus.out_clone_ready = ready;
  assign bus.out_stall       = stall;
  assign bus.out_rd_addr     = rd_addr;
  assign bus.out_copy_en     = copy_vld_q ? mask_q : '0;
  assign bus.out_copy_rd     = copy_rd_q;
  assign bus.out_copy_data   = copy_data_q;
  assign bus.out_done        = done;

endmodule

// File: tb/tb_vx_clone_sequencer.sv
// Self-checking bench for vx_clone_sequencer. The master register file and the slave register
// files are modelled as plain arrays; after each clone every selected slave must equal the
// master and every other lane must be untouched.
module tb_vx_clone_sequencer;
  import vx_clone_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_clone_sequencer_if bus ();

  vx_clone_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] m [NUM_REGS];
  logic [31:0] s [NT][NUM_REGS];
  int n_checks = 0;
  int n_pass   = 0;

  assign bus.in_rd_data = m[bus.out_rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] sentinel(input int l, input int r);
    return 32'hF000_0000 | 32'(l << 8) | 32'(r);
  endfunction

  task automatic init_slaves();
    for (int l = 0; l < NT; l++)
      for (int r = 0; r < NUM_REGS; r++) s[l][r] = sentinel(l, r);
  endtask

  task automatic coherence(input logic [NT-1:0] em);
    for (int l = 0; l < NT; l++) begin
      int bad;
      bad = 0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (s[l][r] !== (em[l] ? m[r] : sentinel(l, r))) bad++;
      end
      check($sformatf("coherent_lane%0d", l), bad, 0);
    end
  endtask

  // Call at a negedge with the DUT idle: raises the request for the accepting edge.
  task automatic start_clone(input logic [NT-1:0] mask);
    bus.in_clone_valid = 1'b1;
    bus.in_clone_mask  = mask;
    #1;
    check("acc_ready", bus.out_clone_ready, 1);
    check("acc_stall", bus.out_stall, 1);
  endtask

  // mode 0: no wb; 1: wb r5 bypass; 2: wb r3 after its read; 3: random wb; 4: reset at cycle 15
  task automatic track_clone(input int mode, input logic [NT-1:0] em, input bit rereq,
                             output int done_cyc);
    logic          wbv;
    logic [RW-1:0] wbr;
    logic [31:0]   wbd;
    wbv = 1'b0; wbr = '0; wbd = '0;
    done_cyc = -1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (wbv) m[wbr] = wbd;
      for (int l = 0; l < NT; l++)
        if (bus.out_copy_en[l]) s[l][bus.out_copy_rd] = bus.out_copy_data;
      if (cyc == 1) bus.in_clone_valid = 1'b0;
      if (rereq && cyc == 5) begin
        bus.in_clone_valid = 1'b1;
        bus.in_clone_mask  = 4'b1110;
      end
      check("busy_stall", bus.out_stall, 1);
      check("busy_ready", bus.out_clone_ready, 0);
      if ((mode <= 1 && cyc >= 2 && cyc <= 32) || bus.out_copy_en != '0)
        check("copy_en", bus.out_copy_en, em);
      if (mode <= 1 && cyc >= 2 && cyc <= 32) begin
        check("copy_rd", bus.out_copy_rd, cyc - 1);
        check("copy_data", bus.out_copy_data, m[bus.out_copy_rd]);
      end
      if (mode == 2 && cyc == 33) begin
        check("fixup_rd", bus.out_copy_rd, 3);
        check("fixup_data", bus.out_copy_data, 32'hBEEF);
      end
      if (bus.out_done) begin
        done_cyc = cyc;
        wbv = 1'b0;
        break;
      end
      if (mode == 4 && cyc == 15) begin
        reset = 1'b1;
        done_cyc = cyc;
        wbv = 1'b0;
        break;
      end
      wbv = 1'b0;
      case (mode)
        1: if (cyc == 5) begin
          check("bypass_rd_addr", bus.out_rd_addr, 5);
          wbv = 1'b1; wbr = RW'(5); wbd = 32'hDEAD;
        end
        2, 4: if (cyc == 10) begin
          wbv = 1'b1; wbr = RW'(3); wbd = (mode == 2) ? 32'hBEEF : 32'h1234_5678;
        end
        3: if ($urandom_range(0, 2) == 0) begin
          wbv = 1'b1; wbr = RW'($urandom_range(0, NUM_REGS - 1)); wbd = $urandom;
        end
        default: ;
      endcase
      bus.in_wb_valid = wbv;
      bus.in_wb_rd    = wbr;
      bus.in_wb_data  = wbd;
    end
    bus.in_wb_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_ready"}, bus.out_clone_ready, 1);
    check({tag, "_done"}, bus.out_done, 0);
  endtask

  initial begin
    int d;
    logic [NT-1:0] rm;
    reset              = 1'b1;
    bus.in_clone_valid = 1'b0;
    bus.in_clone_mask  = '0;
    bus.in_wb_valid    = 1'b0;
    bus.in_wb_rd       = '0;
    bus.in_wb_data     = '0;
    for (int r = 0; r < NUM_REGS; r++) m[r] = 32'(r * 16);
    init_slaves();
    repeat (2) @(negedge clk);
    check("rst_ready", bus.out_clone_ready, 1);
    check("rst_stall", bus.out_stall, 0);
    check("rst_copy_en", bus.out_copy_en, 0);
    check("rst_copy_rd", bus.out_copy_rd, 0);
    check("rst_copy_data", bus.out_copy_data, 0);
    check("rst_rd_addr", bus.out_rd_addr, 0);
    check("rst_done", bus.out_done, 0);
    reset = 1'b0;
    @(negedge clk);

    // Nominal clone, no writebacks.
    start_clone(4'b1110);
    track_clone(0, 4'b1110, 1'b0, d);
    check("nominal_done_cyc", d, 33);
    coherence(4'b1110);
    check_idle("nominal_idle");

    // Master-only mask: nothing to copy.
    init_slaves();
    start_clone(4'b0001);
    track_clone(0, 4'b0000, 1'b0, d);
    check("empty_done_cyc", d, 1);
    coherence(4'b0000);
    check_idle("empty_idle");

    // Writeback hitting the register being read is bypassed.
    init_slaves();
    start_clone(4'b1110);
    track_clone(1, 4'b1110, 1'b0, d);
    check("bypass_done_cyc", d, 33);
    coherence(4'b1110);
    check_idle("bypass_idle");

    // Writeback to an already-copied register forces a fixup copy.
    init_slaves();
    start_clone(4'b1110);
    track_clone(2, 4'b1110, 1'b0, d);
    check("fixup_done_cyc", d, 34);
    coherence(4'b1110);
    check_idle("fixup_idle");

    // Second request raised mid-clone is held off, then accepted right after done.
    init_slaves();
    start_clone(4'b0110);
    track_clone(0, 4'b0110, 1'b1, d);
    check("rereq_first_done", d, 33);
    coherence(4'b0110);
    @(negedge clk);
    check("rereq_ready", bus.out_clone_ready, 1);
    check("rereq_stall", bus.out_stall, 1);
    init_slaves();
    track_clone(0, 4'b1110, 1'b0, d);
    check("rereq_second_done", d, 33);
    coherence(4'b1110);
    check_idle("rereq_idle");

    // Reset mid-clone with a dirty register pending; the next clone must be clean.
    start_clone(4'b1010);
    track_clone(4, 4'b1010, 1'b0, d);
    @(negedge clk);
    check("midrst_copy_en", bus.out_copy_en, 0);
    check("midrst_stall", bus.out_stall, 0);
    check("midrst_ready", bus.out_clone_ready, 1);
    check("midrst_done", bus.out_done, 0);
    reset = 1'b0;
    init_slaves();
    start_clone(4'b1110);
    track_clone(0, 4'b1110, 1'b0, d);
    check("midrst_restart_done", d, 33);
    coherence(4'b1110);
    check_idle("midrst_idle");

    // Randomized masks and writeback traffic.
    for (int t = 0; t < 8; t++) begin
      rm = NT'($urandom);
      init_slaves();
      start_clone(rm);
      track_clone(3, rm & 4'b1110, 1'b0, d);
      if ((rm & 4'b1110) == '0) check("rnd_done_empty", d, 1);
      else check("rnd_done_range", 32'(d >= 33 && d <= 200), 1);
      coherence(rm & 4'b1110);
      check_idle("rnd_idle");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
